pool_tile_framer: RTL

//  Upstream feeder for the 2x2 max-pooling stage. Accepts a raster-order stream of
//  DW-bit pixels over a valid/ready handshake and assembles them into a ROWSxCOLS

---
 rtl/pool_tile_framer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pool_tile_framer.sv
// pool_tile_framer
//   Collects a raster-order pixel stream into a ROWS x COLS tile and presents the
//   whole tile in parallel to the 2x2 max-pooling stage. A fill bank collects the
//   next tile while the output bank holds the current one.
//
//   Build option: POOL_SOF_RESYNC_EN
//     defined   -> an accepted in_sof pixel restarts the tile at index 0; a
//                  restart on a partial tile sets the sticky sync_err.
//     undefined -> in_sof is ignored, sync_err is 0, framing is by count only.
//
//   Ports
//     clk, rst_n              clock, asynchronous active-low reset
//     in_valid/in_ready       pixel handshake (in_ready is registered)
//     in_pixel, in_sof        pixel (raster order) and start-of-tile marker
//     tile_valid/tile_ready   tile handshake toward the pooling stage
//     tile_data               pixel (r,c) at [(r*COLS+c)*DW +: DW]
//     sync_err                sticky resynchronisation flag
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   stFill   | collecting pixels into the fill bank, in_ready=1
//   stFull   | fill bank complete, output bank busy, in_ready=0
module pool_tile_framer #(
  parameter int DW   = 4,
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_pixel,
  input  logic                     in_sof,
  output logic                     tile_valid,
  input  logic                     tile_ready,
  output logic [DW*ROWS*COLS-1:0]  tile_data,
  output logic                     sync_err
);

  localparam int N  = ROWS * COLS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] lastIdx = CW'(N - 1);

  localparam logic [0:0] stFill = 1'b0;
  localparam logic [0:0] stFull = 1'b1;

  logic [0:0]      state;
  logic [CW-1:0]   cnt;
  logic [DW*N-1:0] fillBank;
  logic [DW*N-1:0] nextFill;
  logic [CW-1:0]   wrIdx;
  logic            accept;
  logic            isSof;
  logic            outFree;
  logic            lastPix;
  logic            loadFromFill;
  logic            loadFromFull;

  always_comb begin
    accept  = in_valid && in_ready;
    outFree = !tile_valid || tile_ready;
`ifdef POOL_SOF_RESYNC_EN
    isSof = in_sof;
`else
    isSof = 1'b0 & in_sof;
`endif
    // A start-of-tile pixel always lands in slot 0, whatever the count says.
    wrIdx   = isSof ? '0 : cnt;
    lastPix = accept && (wrIdx == lastIdx);
    nextFill = fillBank;
    if (accept) begin
      nextFill[int'(wrIdx)*DW +: DW] = in_pixel;
    end
    // Completing pixel goes straight to the output bank when it is free, so the
    // fill side never stalls in a continuous stream.
    loadFromFill = (state == stFill) && lastPix && outFree;
    loadFromFull = (state == stFull) && tile_valid && tile_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= stFill;
      cnt        <= '0;
      fillBank   <= '0;
      in_ready   <= 1'b1;
      tile_valid <= 1'b0;
      tile_data  <= '0;
    end else begin
      if (accept) begin
        fillBank <= nextFill;
      end

      if (state == stFill) begin
        if (accept) begin
          if (lastPix) begin
            if (outFree) begin
              cnt <= '0;
            end else begin
              // Hold the full bank; cnt stays at the last index until transfer.
              state    <= stFull;
              in_ready <= 1'b0;
            end
          end else begin
            cnt <= wrIdx + CW'(1);
          end
        end
      end else begin
        if (loadFromFull) begin
          state    <= stFill;
          cnt      <= '0;
          in_ready <= 1'b1;
        end
      end

      if (loadFromFill) begin
        tile_data <= nextFill;
      end else if (loadFromFull) begin
        tile_data <= fillBank;
      end

      // A load on the handshake edge keeps tile_valid high.
      if (loadFromFill || loadFromFull) begin
        tile_valid <= 1'b1;
      end else if (tile_ready) begin
        tile_valid <= 1'b0;
      end
    end
  end

`ifdef POOL_SOF_RESYNC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err <= 1'b0;
    end else if (accept && isSof && (cnt != '0) && (state == stFill)) begin
      sync_err <= 1'b1;
    end
  end
`else
  assign sync_err = 1'b0;
`endif

endmodule
